// File: rtl/aes_package.sv
// Shared types and constants for the iterative AES round sequencer.
package aes_package;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        OUT   = 2'd2
    } aes_round_state_t;

    localparam logic [1:0] AES_KEY_128     = 2'b00;
    localparam logic [1:0] AES_KEY_192     = 2'b01;
    localparam logic [1:0] AES_KEY_256     = 2'b10;
    localparam logic [1:0] AES_KEY_ILLEGAL = 2'b11;

    localparam logic [3:0] AES_NR_128 = 4'd10;
    localparam logic [3:0] AES_NR_192 = 4'd12;
    localparam logic [3:0] AES_NR_256 = 4'd14;

    // The illegal code never reaches here in practice; it is rejected at accept.
    function automatic logic [3:0] aes_nr(input logic [1:0] key_size);
        case (key_size)
            AES_KEY_192: aes_nr = AES_NR_192;
            AES_KEY_256: aes_nr = AES_NR_256;
            default:     aes_nr = AES_NR_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Round sequencer: accepts a block, steps the shared datapath through
// rounds 0..Nr as round keys become available, then presents the result.
module aes_round_ctrl
    import aes_package::*;
#(
    parameter int BLK_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 enable_i,
    input  logic [1:0]           key_size_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 key_start_o,
    input  logic                 key_valid_i,
    output logic                 dp_load_o,
    output logic                 dp_round_en_o,
    output logic                 dp_addkey_only_o,
    output logic                 dp_skip_mix_o,
    output logic [3:0]           round_o,
    output logic                 busy_o,
    output logic                 err_key_size_o,
    output logic [BLK_CNT_W-1:0] blocks_done_o
);

    aes_round_state_t     state;
    logic [3:0]           round_q;
    logic [3:0]           nr_q;
    logic                 err_q;
    logic [BLK_CNT_W-1:0] done_q;
    logic                 key_ok;
    logic                 accept;

    assign key_ok = (key_size_i != AES_KEY_ILLEGAL);

    // clear wins over any handshake in the same cycle, so it masks accepts and round pulses.
    assign in_ready_o       = (state == IDLE) & enable_i & key_ok & ~clear;
    assign accept           = in_valid_i & in_ready_o;
    assign dp_load_o        = accept;
    assign key_start_o      = accept;
    assign dp_round_en_o    = (state == ROUND) & key_valid_i & enable_i & ~clear;
    assign dp_addkey_only_o = dp_round_en_o & (round_q == 4'd0);
    assign dp_skip_mix_o    = dp_round_en_o & (round_q == nr_q);

    assign out_valid_o    = (state == OUT);
    assign busy_o         = (state != IDLE);
    assign round_o        = round_q;
    assign err_key_size_o = err_q;
    assign blocks_done_o  = done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            round_q <= 4'd0;
            nr_q    <= AES_NR_128;
            err_q   <= 1'b0;
            done_q  <= '0;
        end else if (clear) begin
            state   <= IDLE;
            round_q <= 4'd0;
            nr_q    <= AES_NR_128;
            err_q   <= 1'b0;
            done_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        nr_q    <= aes_nr(key_size_i);
                        round_q <= 4'd0;
                        state   <= ROUND;
                    end
                    if (in_valid_i & enable_i & ~key_ok) begin
                        err_q <= 1'b1;
                    end
                end
                ROUND: begin
                    if (dp_round_en_o) begin
                        if (round_q == nr_q) begin
                            state <= OUT;
                        end else begin
                            round_q <= round_q + 4'd1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready_i) begin
                        done_q  <= done_q + 1'b1;
                        round_q <= 4'd0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a scoreboard of expected block results.
module tb_aes_round_ctrl;

    localparam int BLK_CNT_W = 2;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 clear = 1'b0;
    logic                 enable_i = 1'b0;
    logic [1:0]           key_size_i = 2'b00;
    logic                 in_valid_i = 1'b0;
    logic                 in_ready_o;
    logic                 out_valid_o;
    logic                 out_ready_i = 1'b0;
    logic                 key_start_o;
    logic                 key_valid_i = 1'b0;
    logic                 dp_load_o;
    logic                 dp_round_en_o;
    logic                 dp_addkey_only_o;
    logic                 dp_skip_mix_o;
    logic [3:0]           round_o;
    logic                 busy_o;
    logic                 err_key_size_o;
    logic [BLK_CNT_W-1:0] blocks_done_o;

    typedef struct {
        int latency;
        int pulses;
        int last_round;
        int done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_done = 0;

    aes_round_ctrl #(.BLK_CNT_W(BLK_CNT_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .clear            (clear),
        .enable_i         (enable_i),
        .key_size_i       (key_size_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .key_start_o      (key_start_o),
        .key_valid_i      (key_valid_i),
        .dp_load_o        (dp_load_o),
        .dp_round_en_o    (dp_round_en_o),
        .dp_addkey_only_o (dp_addkey_only_o),
        .dp_skip_mix_o    (dp_skip_mix_o),
        .round_o          (round_o),
        .busy_o           (busy_o),
        .err_key_size_o   (err_key_size_o),
        .blocks_done_o    (blocks_done_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full block: accept, rounds with optional key/enable stalls, delayed output handshake.
    task automatic apply_stimulus(input logic [1:0] ks, input int kv_round, input int kv_len,
                                  input int en_round, input int en_len, input int out_delay);
        exp_t e;
        exp_t got;
        int   nr;
        int   cyc;
        int   pulses;
        int   kv_left;
        int   en_left;
        int   addkey_idx;
        int   skip_idx;
        int   skip_round;
        bit   seen;

        nr = (ks == 2'b00) ? 10 : (ks == 2'b01) ? 12 : 14;
        exp_done     = (exp_done + 1) % (1 << BLK_CNT_W);
        e.latency    = nr + 2 + kv_len + en_len;
        e.pulses     = nr + 1;
        e.last_round = nr;
        e.done       = exp_done;
        sb.push_back(e);

        step();
        enable_i    = 1'b1;
        key_size_i  = ks;
        in_valid_i  = 1'b1;
        key_valid_i = 1'b1;
        out_ready_i = 1'b0;
        #1;
        check_output("accept_ready", in_ready_o, 1);
        check_output("accept_load", dp_load_o, 1);
        check_output("accept_key_start", key_start_o, 1);

        cyc = 0; pulses = 0; seen = 0;
        kv_left = kv_len; en_left = en_len;
        addkey_idx = -1; skip_idx = -1; skip_round = -1;
        while (!seen && cyc < 60) begin
            step();
            cyc++;
            in_valid_i  = 1'b0;
            key_size_i  = ks ^ 2'b01;
            key_valid_i = 1'b1;
            enable_i    = 1'b1;
            if (int'(round_o) == kv_round && kv_left > 0) begin
                key_valid_i = 1'b0;
                kv_left--;
            end else if (int'(round_o) == en_round && en_left > 0) begin
                enable_i = 1'b0;
                en_left--;
            end
            #1;
            if (out_valid_o) begin
                seen = 1;
            end else begin
                if (!key_valid_i || !enable_i) check_output("stall_no_pulse", dp_round_en_o, 0);
                if (dp_round_en_o) begin
                    pulses++;
                    if (dp_addkey_only_o) addkey_idx = pulses;
                    if (dp_skip_mix_o) begin
                        skip_idx   = pulses;
                        skip_round = round_o;
                    end
                end
            end
        end
        if (!seen) check_output("out_valid_timeout", 0, 1);

        got = sb.pop_front();
        check_output("latency", cyc, got.latency);
        check_output("pulse_count", pulses, got.pulses);
        check_output("addkey_first", addkey_idx, 1);
        check_output("skip_last", skip_idx, got.pulses);
        check_output("skip_round", skip_round, got.last_round);

        for (int d = 0; d < out_delay; d++) begin
            step();
            in_valid_i  = 1'b1;
            key_size_i  = ks;
            out_ready_i = 1'b0;
            #1;
            check_output("out_hold_valid", out_valid_o, 1);
            check_output("out_hold_no_ready", in_ready_o, 0);
            check_output("out_hold_no_load", dp_load_o, 0);
        end
        step();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        #1;
        check_output("handshake_valid", out_valid_o, 1);
        step();
        out_ready_i = 1'b0;
        #1;
        check_output("post_busy", busy_o, 0);
        check_output("post_out_valid", out_valid_o, 0);
        check_output("post_round", round_o, 0);
        check_output("blocks_done", blocks_done_o, got.done);
    endtask

    initial begin
        bit any_out;

        // Reset values while reset_n is held low.
        #1;
        check_output("rst_round", round_o, 0);
        check_output("rst_busy", busy_o, 0);
        check_output("rst_out_valid", out_valid_o, 0);
        check_output("rst_err", err_key_size_o, 0);
        check_output("rst_blocks", blocks_done_o, 0);
        check_output("rst_round_en", dp_round_en_o, 0);
        check_output("rst_ready_disabled", in_ready_o, 0);
        enable_i = 1'b1;
        #1;
        check_output("rst_ready_enabled", in_ready_o, 1);
        enable_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        apply_stimulus(2'b00, -1, 0, -1, 0, 0);
        apply_stimulus(2'b10, -1, 0, -1, 0, 0);
        apply_stimulus(2'b01, -1, 0, -1, 0, 0);
        // Fourth block wraps the 2-bit counter back to zero.
        apply_stimulus(2'b00, 5, 3, 8, 2, 5);

        // Illegal key size.
        step();
        enable_i   = 1'b1;
        key_size_i = 2'b11;
        in_valid_i = 1'b1;
        #1;
        check_output("illegal_ready", in_ready_o, 0);
        check_output("illegal_load", dp_load_o, 0);
        step();
        in_valid_i = 1'b0;
        key_size_i = 2'b00;
        #1;
        check_output("illegal_err", err_key_size_o, 1);
        check_output("illegal_busy", busy_o, 0);
        repeat (3) step();
        check_output("illegal_err_sticky", err_key_size_o, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        #1;
        check_output("clear_err", err_key_size_o, 0);
        exp_done = 0;

        // Clear in the middle of round 4.
        step();
        in_valid_i  = 1'b1;
        key_size_i  = 2'b00;
        key_valid_i = 1'b1;
        #1;
        check_output("clr_accept", dp_load_o, 1);
        for (int i = 0; i < 20; i++) begin
            step();
            in_valid_i = 1'b0;
            #1;
            if (round_o == 4'd4) break;
        end
        check_output("clr_reached_round4", round_o, 4);
        clear = 1'b1;
        #1;
        check_output("clr_priority_no_pulse", dp_round_en_o, 0);
        step();
        clear = 1'b0;
        #1;
        check_output("clr_busy", busy_o, 0);
        check_output("clr_round", round_o, 0);
        any_out = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid_o) any_out = 1;
        end
        check_output("clr_no_out_valid", any_out, 0);

        apply_stimulus(2'b00, -1, 0, -1, 0, 0);

        // Asynchronous reset in the middle of a block.
        step();
        in_valid_i = 1'b1;
        #1;
        step();
        in_valid_i = 1'b0;
        repeat (3) step();
        check_output("arst_pre_busy", busy_o, 1);
        reset_n = 1'b0;
        #1;
        check_output("arst_busy", busy_o, 0);
        check_output("arst_round", round_o, 0);
        check_output("arst_round_en", dp_round_en_o, 0);
        check_output("arst_out_valid", out_valid_o, 0);
        check_output("arst_blocks", blocks_done_o, 0);
        exp_done = 0;
        @(negedge clk);
        reset_n = 1'b1;

        apply_stimulus(2'b10, -1, 0, -1, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
